// File: rtl/pulse_generator_multi.sv
// pulse_generator_multi
//   CHANNELS independent pulse-train generators sharing clock, reset, a global
//   enable and a global phase-sync strobe. Each channel counts 0..period-1 and
//   drives out high for the first width cycles of every period. In one-shot
//   mode a start strobe runs exactly one period.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low
//   ena      : global enable; low gates all outputs, clears counters, aborts one-shots
//   sync     : restarts every running channel at count 0 and suppresses its wrap
//   ticks    : per-channel period, channel c at [c*N +: N]
//   width    : per-channel high time, same packing
//   oneshot  : per-channel mode (1 one-shot, 0 continuous)
//   start    : per-channel one-shot trigger
//   out      : pulse outputs
//   wrap     : strobe on the last cycle of each period
//   busy     : channel running
module pulse_generator_multi #(
  parameter int N        = 8,
  parameter int CHANNELS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  sync,
  input  logic [CHANNELS*N-1:0] ticks,
  input  logic [CHANNELS*N-1:0] width,
  input  logic [CHANNELS-1:0]   oneshot,
  input  logic [CHANNELS-1:0]   start,
  output logic [CHANNELS-1:0]   out,
  output logic [CHANNELS-1:0]   wrap,
  output logic [CHANNELS-1:0]   busy
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]        cnt_q    [CHANNELS];
  logic [N-1:0]        cnt_d    [CHANNELS];
  logic [N-1:0]        period_q [CHANNELS];
  logic [N-1:0]        period_d [CHANNELS];
  logic [N-1:0]        width_q  [CHANNELS];
  logic [N-1:0]        width_d  [CHANNELS];
  logic [CHANNELS-1:0] mode_q, mode_d;
  logic [CHANNELS-1:0] run_q, run_d;
  logic [CHANNELS-1:0] active;
  logic [CHANNELS-1:0] last;

  always_comb begin
    active = '0;
    last   = '0;
    out    = '0;
    wrap   = '0;
    busy   = '0;
    mode_d = mode_q;
    run_d  = run_q;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_d[c]    = '0;
      period_d[c] = period_q[c];
      width_d[c]  = width_q[c];

      active[c] = ena & (period_q[c] != '0) & (~mode_q[c] | run_q[c]);
      // active guarantees period_q != 0, so the subtraction never underflows
      last[c]   = active[c] & (cnt_q[c] == period_q[c] - ONE);
      out[c]    = active[c] & (cnt_q[c] < width_q[c]);
      // sync wins over a coincident period end
      wrap[c]   = last[c] & ~sync;
      busy[c]   = active[c];

      if (active[c] && !sync && !wrap[c])
        cnt_d[c] = cnt_q[c] + ONE;

      // Shadows follow the inputs while idle and are refreshed only at a
      // period boundary while running, so a period is never reshaped mid-way.
      if (!active[c] || wrap[c]) begin
        period_d[c] = ticks[c*N +: N];
        width_d[c]  = width[c*N +: N];
        mode_d[c]   = oneshot[c];
      end

      if (!ena)
        run_d[c] = 1'b0;
      else if (run_q[c] && wrap[c])
        run_d[c] = 1'b0;
      else if (!run_q[c] && start[c] && mode_q[c] && (period_q[c] != '0))
        run_d[c] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c]    <= '0;
        period_q[c] <= '0;
        width_q[c]  <= '0;
      end
      mode_q <= '0;
      run_q  <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c]    <= cnt_d[c];
        period_q[c] <= period_d[c];
        width_q[c]  <= width_d[c];
      end
      mode_q <= mode_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: tb/tb_pulse_generator_multi.sv
module tb_pulse_generator_multi;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        sync;
  logic [31:0] ticks;
  logic [31:0] width;
  logic [3:0]  oneshot;
  logic [3:0]  start;
  logic [3:0]  out;
  logic [3:0]  wrap;
  logic [3:0]  busy;

  int checks = 0;
  int errors = 0;

  pulse_generator_multi #(.N(8), .CHANNELS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .sync    (sync),
    .ticks   (ticks),
    .width   (width),
    .oneshot (oneshot),
    .start   (start),
    .out     (out),
    .wrap    (wrap),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [7:0] t, input logic [7:0] w);
    ticks[c*8 +: 8] = t;
    width[c*8 +: 8] = w;
  endtask

  // move to just after the next rising edge
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  e_out, e_wrap;
  logic [13:0] s_out0, s_out3, s_busy3;

  initial begin
    rst = 1'b0; ena = 1'b0; sync = 1'b0;
    ticks = '0; width = '0; oneshot = '0; start = '0;
    set_ch(0, 8'd5, 8'd2);
    set_ch(1, 8'd1, 8'd1);
    set_ch(2, 8'd0, 8'd3);
    set_ch(3, 8'd4, 8'd9);
    #1;
    chk("rst_out",  out,  4'h0);
    chk("rst_wrap", wrap, 4'h0);
    chk("rst_busy", busy, 4'h0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("idle_busy", busy, 4'h0);

    // continuous plus boundary channels
    for (int k = 0; k < 12; k++) begin
      adv();
      if (k == 0) ena = 1'b1;
      #1;
      e_out  = {1'b1, 1'b0, 1'b1, ((k % 5) < 2) ? 1'b1 : 1'b0};
      e_wrap = {((k % 4) == 3) ? 1'b1 : 1'b0, 1'b0, 1'b1, ((k % 5) == 4) ? 1'b1 : 1'b0};
      chk($sformatf("cont_out k%0d", k),  out,  e_out);
      chk($sformatf("cont_wrap k%0d", k), wrap, e_wrap);
      chk($sformatf("cont_busy k%0d", k), busy, 4'b1011);
    end

    // asynchronous reset in the middle of a period
    adv();
    #1 rst = 1'b0;
    #1;
    chk("arst_out",  out,  4'h0);
    chk("arst_wrap", wrap, 4'h0);
    chk("arst_busy", busy, 4'h0);
    #3 rst = 1'b1;
    #1 chk("post_rst_busy", busy, 4'h0);
    for (int k = 0; k < 5; k++) begin
      adv();
      #1;
      chk($sformatf("rst_restart_out k%0d", k),  out[0],  (k < 2) ? 1'b1 : 1'b0);
      chk($sformatf("rst_restart_wrap k%0d", k), wrap[0], (k == 4) ? 1'b1 : 1'b0);
      chk($sformatf("rst_restart_busy k%0d", k), busy[0], 1'b1);
    end

    // config change mid-period only applies at the boundary
    adv();
    ena = 1'b0;
    set_ch(0, 8'd6, 8'd2);
    #1;
    chk("ena_off_out",  out,  4'h0);
    chk("ena_off_busy", busy, 4'h0);
    for (int k = 0; k < 12; k++) begin
      adv();
      if (k == 0) ena = 1'b1;
      if (k == 2) set_ch(0, 8'd3, 8'd2);
      #1;
      if (k < 6) begin
        chk($sformatf("cfg_out k%0d", k),  out[0],  (k < 2) ? 1'b1 : 1'b0);
        chk($sformatf("cfg_wrap k%0d", k), wrap[0], (k == 5) ? 1'b1 : 1'b0);
      end else begin
        chk($sformatf("cfg_out k%0d", k),  out[0],  (((k - 6) % 3) < 2) ? 1'b1 : 1'b0);
        chk($sformatf("cfg_wrap k%0d", k), wrap[0], (((k - 6) % 3) == 2) ? 1'b1 : 1'b0);
      end
    end

    // ena dropped at cnt=3
    adv();
    ena = 1'b0;
    set_ch(0, 8'd5, 8'd2);
    #1;
    for (int k = 0; k < 7; k++) begin
      adv();
      ena = (k != 3);
      #1;
      chk($sformatf("ena_out k%0d", k),  out[0],  (k == 0 || k == 1 || k == 4 || k == 5) ? 1'b1 : 1'b0);
      chk($sformatf("ena_busy k%0d", k), busy[0], (k != 3) ? 1'b1 : 1'b0);
      chk($sformatf("ena_wrap k%0d", k), wrap[0], 1'b0);
      if (k == 3) chk("ena_all_busy", busy, 4'h0);
    end

    // sync aligns two channels at different phases
    adv();
    ena = 1'b0;
    set_ch(0, 8'd8, 8'd4);
    set_ch(1, 8'd0, 8'd0);
    set_ch(3, 8'd0, 8'd0);
    #1;
    s_out0  = 14'b10000111101111;
    s_out3  = 14'b10000111111110;
    s_busy3 = 14'b11111111111110;
    for (int k = 0; k < 14; k++) begin
      adv();
      if (k == 0) begin
        ena = 1'b1;
        set_ch(3, 8'd8, 8'd4);
      end
      sync = (k == 4 || k == 12);
      #1;
      chk($sformatf("sync_out0 k%0d", k),  out[0],  s_out0[k]);
      chk($sformatf("sync_out3 k%0d", k),  out[3],  s_out3[k]);
      chk($sformatf("sync_busy3 k%0d", k), busy[3], s_busy3[k]);
      chk($sformatf("sync_wrap k%0d", k),  wrap,    4'h0);
    end

    // one-shot, with a retrigger attempt while busy
    adv();
    ena = 1'b0;
    sync = 1'b0;
    set_ch(0, 8'd3, 8'd1);
    oneshot[0] = 1'b1;
    #1;
    for (int k = 0; k < 7; k++) begin
      adv();
      ena = 1'b1;
      start[0] = (k == 1 || k == 3);
      start[2] = (k == 1);
      #1;
      chk($sformatf("os_busy k%0d", k),  busy[0], (k >= 2 && k <= 4) ? 1'b1 : 1'b0);
      chk($sformatf("os_out k%0d", k),   out[0],  (k == 2) ? 1'b1 : 1'b0);
      chk($sformatf("os_wrap k%0d", k),  wrap[0], (k == 4) ? 1'b1 : 1'b0);
      chk($sformatf("os_busy2 k%0d", k), busy[2], 1'b0);
    end
    start = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_generator_multi.md
Name: pulse_generator_multi

Overview:
Multi-channel successor to the single-channel pulse generator. Each of CHANNELS independent channels produces a pulse train with a programmable period and high-time, in either continuous or one-shot mode. Each channel also drives a per-period wrap strobe and a busy flag. Used for PWM, strobes and timed enables. All channels share one clock, one reset, a global enable and a global phase-sync input.

Parameters:
N, 8, width of per-channel period/high-time/counter
CHANNELS, 4, number of independent channels

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (rst=0 resets)
ena  input  1  global enable; 0 gates all outputs and clears counters
sync  input  1  synchronous strobe; restarts all running channels at count 0
ticks  input  CHANNELS*N  per-channel period in cycles; channel c uses [c*N +: N]
width  input  CHANNELS*N  per-channel high-time in cycles, same packing
oneshot  input  CHANNELS  per-channel mode: 1 one-shot, 0 continuous
start  input  CHANNELS  per-channel one-shot trigger, single-cycle
out  output  CHANNELS  pulse outputs
wrap  output  CHANNELS  one-cycle strobe on last cycle of each period
busy  output  CHANNELS  channel is running

Behaviour:
- Per-channel state registers:
  - cnt[N]
  - period_q[N], width_q[N], mode_q (shadow config)
  - run (one-shot running flag)
- Reset (rst=0, async): all registers 0; out=wrap=busy=0.
- Shadow load: period_q/width_q/mode_q load from ticks/width/oneshot every cycle the channel is not active, and on the cycle the channel wraps. Config changes take effect only at a period boundary, never mid-period.
- active = ena & (period_q != 0) & (mode_q==0 | run).
- Outputs are combinational from registers and ena; there is no extra latency:
  - out = active & (cnt < width_q)
  - wrap = active & (cnt == period_q-1)
  - busy = active
- Counter:
  - If active and not wrapping: cnt <= cnt+1.
  - If wrapping (wrap=1): cnt <= 0.
  - If not active: cnt <= 0.
- Period is exactly period_q cycles. out is high for the first min(width_q, period_q) cycles of each period.
- width_q=0: out never high. width_q>=period_q: out held high while active.
- period_q=0: channel disabled; out/wrap/busy=0; start ignored.
- period_q=1: wrap every active cycle; cnt stays 0.
- One-shot:
  - idle = (run==0). start=1 while idle, ena=1, mode_q=1 and period_q!=0 sets run<=1.
  - busy rises the next cycle. The pulse occupies exactly one period.
  - On wrap, run<=0; busy falls the cycle after the wrap strobe.
  - start while run=1 is ignored (no retrigger).
  - start with mode_q=0 is ignored.
- ena=0 at any time: outputs drop that cycle, cnt<=0, run<=0 (aborts one-shot). Shadows then track inputs.
- sync=1: every active channel gets cnt<=0 and wrap is suppressed that cycle; run is unchanged. sync overrides a coincident wrap. Shadows do not reload on sync.
- start and sync in the same cycle: start sets run and cnt stays 0.
- Channels are fully independent except for the shared ena and sync.
- All arithmetic is unsigned N-bit. period_q-1 is evaluated only when period_q!=0.

Test Plan:
- Reset mid-run: ch0 continuous ticks=5, width=2, running; rst=0 asynchronously mid-cycle -> out/wrap/busy=0 immediately; after release with ena=1 the period restarts from cnt=0.
- Continuous: ch0 ticks=5, width=2, ena=1 -> out pattern 1,1,0,0,0 repeating; wrap high on the 5th cycle of each period; busy constant 1.
- Boundary values: ch1 ticks=1, width=1 -> out and wrap constant 1. ch2 ticks=0 -> all ch2 outputs 0. ch3 ticks=4, width=9 -> out constant 1, wrap every 4th cycle.
- One-shot: ch0 oneshot=1, ticks=3, width=1, start pulse -> busy high for 3 cycles starting next cycle; out high on the first of them; wrap on the third. A second start during busy produces no extra period.
- Config change mid-period: continuous ticks=6 running; change ticks to 3 at cnt=2 -> the current period still lasts 6 cycles; subsequent periods last 3.
- Global controls: ena dropped at cnt=3 -> outputs 0 that cycle; restart from cnt=0 when ena returns. sync at cnt=4 with ticks=8 on two channels at different phases -> both counters at 0 the next cycle and in lockstep afterwards.
